if_fetch_stage: RTL

//  Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC register,

---
 rtl/if_fetch_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the PC,
//   drives the instruction-memory address and the external PC+4 adder, and
//   loads the IF/ID pipeline register. It also handles imem wait states,
//   hazard stalls and branch/jump redirects from EX.
//
//   Optional feature macro: BRANCH_DELAY_SLOT_EN
//     When defined, MIPS delay-slot semantics apply. The word fetched while a
//     redirect is taken is kept valid in IF/ID instead of being squashed.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active-high
//   stall          hazard unit: hold PC and IF/ID
//   branch_taken   redirect request from EX
//   branch_target  redirect address, valid with branch_taken
//   pc_plus4_in    PC+4 adder result (adder inputs are pc_out and 4)
//   instr_in       imem read data, valid when imem_ready=1
//   imem_ready     imem has data for pc_out this cycle
//   pc_out         registered PC: imem address and adder input
//   imem_req       fetch request, low only in BOOT
//   if_id_pc4      IF/ID: PC+4 of the held instruction
//   if_id_instr    IF/ID: instruction word
//   if_id_valid    IF/ID: 1 = real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] pc_plus4_in,
    input  logic [31:0] instr_in,
    input  logic        imem_ready,
    output logic [31:0] pc_out,
    output logic        imem_req,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_BOOT          = 2'd0,
        ST_FETCH         = 2'd1,
        ST_REDIRECT_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pending_q, pending_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   redirect_pc;

    // Next-state and IF/ID load logic; priority is branch_taken > stall > normal.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pending_d   = pending_q;
        pc4_d       = pc4_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        req_d       = 1'b1;
        // A branch arriving while a redirect is outstanding replaces it.
        redirect_pc = branch_taken ? branch_target : pending_q;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (branch_taken) begin
                    if (imem_ready) begin
                        pc_d = branch_target;
`ifdef BRANCH_DELAY_SLOT_EN
                        pc4_d   = pc_plus4_in;
                        instr_d = instr_in;
                        valid_d = 1'b1;
`else
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
`endif
                    end else begin
                        pending_d = branch_target;
                        instr_d   = NOP_INSTR;
                        valid_d   = 1'b0;
                        state_d   = ST_REDIRECT_WAIT;
                    end
                end else if (stall) begin
                    // Hold everything; imem re-reads the same address.
                end else if (imem_ready) begin
                    pc_d    = pc_plus4_in;
                    pc4_d   = pc_plus4_in;
                    instr_d = instr_in;
                    valid_d = 1'b1;
                end else begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end

            ST_REDIRECT_WAIT: begin
                pending_d = redirect_pc;
`ifdef BRANCH_DELAY_SLOT_EN
                // The word returned here is the delay slot, so a stall holds
                // the whole completion rather than just IF/ID.
                if (branch_taken || !stall) begin
                    if (imem_ready) begin
                        pc_d    = redirect_pc;
                        pc4_d   = pc_plus4_in;
                        instr_d = instr_in;
                        valid_d = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end
`else
                // Returned word belongs to the old path and is dropped; a stall
                // only freezes IF/ID, never the redirect itself.
                if (imem_ready) begin
                    pc_d    = redirect_pc;
                    state_d = ST_FETCH;
                end
                if (branch_taken || !stall) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
`endif
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            pending_q <= '0;
            pc4_q     <= '0;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            pc4_q     <= pc4_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            req_q     <= req_d;
        end
    end

    assign pc_out      = pc_q;
    assign imem_req    = req_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_instr = instr_q;
    assign if_id_valid = valid_q;

endmodule
